// File: rtl/mul_share_pkg.sv
// Shared types for the multiplier-sharing scheduler: FSM states, result tag and width helpers.
package mul_share_pkg;

    localparam int OP_W_DEF = 2;
    // Wide enough for the largest supported requester count (8).
    localparam int TAG_ID_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

    function automatic int prod_w(input int op_w);
        return 2 * op_w;
    endfunction

endpackage

// File: rtl/mul_share_ctrl_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched upward from a rotating pointer.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable_i,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    win_id_o,
    output logic               win_valid_o
);

    logic [ID_W-1:0] ptr_q, ptr_d;

    // NOTE: every output gets a default before the search loop so no latch is inferred.
    always_comb begin
        int idx;
        idx         = 0;
        grant_o     = '0;
        win_id_o    = '0;
        win_valid_o = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (enable_i && !win_valid_o && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                win_id_o     = ID_W'(idx);
                win_valid_o  = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (win_valid_o) begin
            ptr_d = (int'(win_id_o) == NUM_REQ - 1) ? '0 : win_id_o + ID_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mul_share_ctrl.sv
// Shares one pipelined multiplier between NUM_REQ requesters and tags results with the owner ID.
// Optional result checker is built when MUL_SHARE_CHECK_EN is defined.
module mul_share_ctrl
    import mul_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int OP_W    = OP_W_DEF,
    parameter int MUL_LAT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    flush,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*OP_W-1:0] req_a,
    input  logic [NUM_REQ*OP_W-1:0] req_b,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [OP_W-1:0]         mul_a,
    output logic [OP_W-1:0]         mul_b,
    input  logic [2*OP_W-1:0]       mul_p,
    output logic                    resp_valid,
    output logic [ID_W-1:0]         resp_id,
    output logic [2*OP_W-1:0]       resp_p,
    output logic                    busy,
    output logic                    flush_done,
    output logic                    chk_err
);

    localparam int P_W = prod_w(OP_W);

    state_e              state_q, state_d;
    logic                arb_en;
    logic                hs;
    logic [ID_W-1:0]     win_id;
    logic [NUM_REQ-1:0]  grant;
    logic [OP_W-1:0]     mul_a_q, mul_a_d;
    logic [OP_W-1:0]     mul_b_q, mul_b_d;
    tag_t                tag_q [MUL_LAT];
    tag_t                tag_d;
    logic                pipe_empty;
    logic                drain_done;
    logic                idle_flush_q, idle_flush_d;

    // flush or a dropped en suppresses the grant in the very same cycle.
    assign arb_en = (state_q == RUN) && en && !flush;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .enable_i    (arb_en),
        .req_i       (req_valid),
        .grant_o     (grant),
        .win_id_o    (win_id),
        .win_valid_o (hs)
    );

    assign req_ready = grant;

    always_comb begin
        mul_a_d = '0;
        mul_b_d = '0;
        tag_d   = '0;
        if (hs) begin
            mul_a_d     = req_a[int'(win_id)*OP_W +: OP_W];
            mul_b_d     = req_b[int'(win_id)*OP_W +: OP_W];
            tag_d.valid = 1'b1;
            tag_d.id    = TAG_ID_W'(win_id);
        end
    end

    always_comb begin
        pipe_empty = 1'b1;
        for (int i = 0; i < MUL_LAT; i++) begin
            if (tag_q[i].valid) pipe_empty = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        drain_done = 1'b0;
        case (state_q)
            IDLE:  if (en && !flush) state_d = RUN;
            RUN:   if (flush || !en) state_d = DRAIN;
            DRAIN: begin
                if (pipe_empty) begin
                    state_d    = IDLE;
                    drain_done = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A flush seen while idle has nothing to drain; acknowledge it one cycle later.
    assign idle_flush_d = (state_q == IDLE) && flush && pipe_empty;

    // NOTE: the tag pipeline is reset because its valid bits alone decide resp_valid;
    // pure data pipes (operand products) need no reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            idle_flush_q <= 1'b0;
            for (int i = 0; i < MUL_LAT; i++) tag_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            idle_flush_q <= idle_flush_d;
            tag_q[0]     <= tag_d;
            for (int i = 1; i < MUL_LAT; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;
    assign resp_valid = tag_q[MUL_LAT-1].valid;
    assign resp_id    = tag_q[MUL_LAT-1].id[ID_W-1:0];
    assign resp_p     = mul_p;
    assign busy       = (state_q != IDLE) || !pipe_empty;
    assign flush_done = drain_done || idle_flush_q;

`ifdef MUL_SHARE_CHECK_EN
    logic [P_W-1:0] ref_q [MUL_LAT];
    logic           chk_err_q;

    // Reference product travels in lockstep with the tag so both reach the end together.
    always_ff @(posedge clk) begin
        ref_q[0] <= P_W'(mul_a_d) * P_W'(mul_b_d);
        for (int i = 1; i < MUL_LAT; i++) ref_q[i] <= ref_q[i-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chk_err_q <= 1'b0;
        end else if (resp_valid && (mul_p != ref_q[MUL_LAT-1])) begin
            chk_err_q <= 1'b1;
        end
    end

    assign chk_err = chk_err_q;
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Bench for mul_share_ctrl: randomized and directed stimulus against a transaction-level model.
module tb_mul_share_ctrl;

    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int OPW = 2;
    localparam int LAT = 4;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_DRAIN = 2;

    localparam int M_CLEAR  = 0;
    localparam int M_HOLD   = 1;
    localparam int M_STREAM = 2;
    localparam int M_RAND   = 3;

    typedef struct {
        int due;
        int id;
        int p;
        bit bad;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              flush;
    logic [N-1:0]      req_valid;
    logic [N*OPW-1:0]  req_a;
    logic [N*OPW-1:0]  req_b;
    logic [N-1:0]      req_ready;
    logic [OPW-1:0]    mul_a;
    logic [OPW-1:0]    mul_b;
    logic [2*OPW-1:0]  mul_p;
    logic              resp_valid;
    logic [IDW-1:0]    resp_id;
    logic [2*OPW-1:0]  resp_p;
    logic              busy;
    logic              flush_done;
    logic              chk_err;

    mul_share_ctrl #(
        .NUM_REQ (N),
        .ID_W    (IDW),
        .OP_W    (OPW),
        .MUL_LAT (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_p      (mul_p),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_p     (resp_p),
        .busy       (busy),
        .flush_done (flush_done),
        .chk_err    (chk_err)
    );

    always #5 clk = ~clk;

    // Multiplier stand-in: product appears LAT cycles after the issue handshake.
    bit               fault_en = 1'b0;
    logic [2*OPW-1:0] p_pipe [LAT-1];

    always @(posedge clk) begin
        p_pipe[0] <= (fault_en && mul_a == 2'd2 && mul_b == 2'd2) ? 4'd5 : 4'(mul_a) * 4'(mul_b);
        for (int i = 1; i < LAT - 1; i++) p_pipe[i] <= p_pipe[i-1];
    end
    assign mul_p = p_pipe[LAT-2];

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model state.
    int   m_state = S_IDLE;
    int   m_ptr   = 0;
    int   m_mul_a = 0;
    int   m_mul_b = 0;
    bit   m_idle_flush = 1'b0;
    bit   m_chk = 1'b0;
    bit   chk_set = 1'b0;
    exp_t q[$];

    int           mode = M_CLEAR;
    int           ti = 0;
    int           n_stream = 0;
    int           n_grants = 0;
    int           resp_cnt = 0;
    logic [N-1:0] last_ready;
    int           ta [8] = '{0, 1, 2, 3, 3, 2, 1, 3};
    int           tb_ [8] = '{3, 2, 1, 0, 3, 2, 3, 1};

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input int a, input int b);
        req_valid[i]         = 1'b1;
        req_a[i*OPW +: OPW]  = OPW'(a);
        req_b[i*OPW +: OPW]  = OPW'(b);
    endtask

    task automatic refill(input int w);
        case (mode)
            M_CLEAR: if (w >= 0) req_valid[w] = 1'b0;
            M_STREAM: begin
                if (w >= 0) begin
                    if (ti < n_stream) begin
                        set_req(w, ta[ti % 8], tb_[ti % 8]);
                        ti++;
                    end else begin
                        req_valid[w] = 1'b0;
                    end
                end
            end
            M_RAND: begin
                for (int i = 0; i < N; i++) begin
                    if (i == w || !req_valid[i]) begin
                        req_valid[i]        = ($urandom_range(0, 2) != 0);
                        req_a[i*OPW +: OPW] = OPW'($urandom);
                        req_b[i*OPW +: OPW] = OPW'($urandom);
                    end
                end
            end
            default: ;
        endcase
    endtask

    // One clock: check outputs at the falling edge, advance the model at the rising edge.
    task automatic tick();
        int             w;
        logic [OPW-1:0] wa, wb;
        bit             pre_empty;
        bit             bad;
        exp_t           e;
        @(negedge clk);
        w  = -1;
        wa = '0;
        wb = '0;
        pre_empty  = (q.size() == 0);
        last_ready = req_ready;
        if (resp_valid === 1'b1) resp_cnt++;
        if (!rst && m_state == S_RUN && en && !flush) w = pick(req_valid, m_ptr);
        if (w >= 0) begin
            wa = req_a[w*OPW +: OPW];
            wb = req_b[w*OPW +: OPW];
            n_grants++;
        end
        if (!rst) begin
            check("req_ready", req_ready, (w >= 0) ? (32'd1 << w) : 32'd0);
            check("busy", busy, (m_state != S_IDLE) || !pre_empty);
            check("flush_done", flush_done, (m_state == S_DRAIN && pre_empty) || m_idle_flush);
            check("mul_a", mul_a, m_mul_a);
            check("mul_b", mul_b, m_mul_b);
            check("chk_err", chk_err, m_chk);
            if (!pre_empty && q[0].due == cyc) begin
                e = q.pop_front();
                check("resp_valid", resp_valid, 1);
                check("resp_id", resp_id, e.id);
                check("resp_p", resp_p, e.p);
                chk_set = e.bad;
            end else begin
                check("resp_valid", resp_valid, 0);
            end
        end
        @(posedge clk);
        if (rst) begin
            m_state = S_IDLE;
            m_ptr   = 0;
            q.delete();
            m_mul_a = 0;
            m_mul_b = 0;
            m_idle_flush = 1'b0;
            m_chk   = 1'b0;
            chk_set = 1'b0;
        end else begin
            m_idle_flush = (m_state == S_IDLE) && flush && pre_empty;
            if (chk_set) m_chk = 1'b1;
            chk_set = 1'b0;
            if (w >= 0) begin
                bad = fault_en && wa == 2'd2 && wb == 2'd2;
                q.push_back('{due: cyc + LAT, id: w, p: bad ? 5 : int'(wa) * int'(wb), bad: bad});
                m_mul_a = int'(wa);
                m_mul_b = int'(wb);
                m_ptr   = (w + 1) % N;
            end else begin
                m_mul_a = 0;
                m_mul_b = 0;
            end
            case (m_state)
                S_IDLE:  if (en && !flush) m_state = S_RUN;
                S_RUN:   if (flush || !en) m_state = S_DRAIN;
                default: if (pre_empty) m_state = S_IDLE;
            endcase
        end
        cyc++;
        #1;
        if (!rst) refill(w);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    int order [5] = '{0, 1, 2, 3, 0};

    initial begin
        rst = 1'b1; en = 1'b0; flush = 1'b0;
        req_valid = '0; req_a = '0; req_b = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Single request: requester 2, 3*2.
        mode = M_CLEAR;
        set_req(2, 3, 2);
        en = 1'b1;
        repeat (7) tick();
        en = 1'b0;
        repeat (4) tick();

        // All requesters held valid from pointer 0.
        do_reset();
        mode = M_HOLD;
        for (int i = 0; i < N; i++) set_req(i, $urandom_range(0, 3), $urandom_range(0, 3));
        en = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            check("grant_order", last_ready, 32'd1 << order[k]);
        end
        en = 1'b0;
        req_valid = '0;
        repeat (8) tick();

        // Eight back-to-back issues from one requester.
        mode = M_STREAM; ti = 1; n_stream = 8;
        set_req(3, ta[0], tb_[0]);
        en = 1'b1;
        resp_cnt = 0;
        repeat (14) tick();
        check("b2b_resp_count", resp_cnt, 8);
        en = 1'b0;
        repeat (4) tick();

        // Flush after three issues, with the request still pending.
        mode = M_STREAM; ti = 1; n_stream = 8;
        set_req(0, ta[0], tb_[0]);
        en = 1'b1;
        n_grants = 0;
        for (int k = 0; k < 10 && n_grants < 3; k++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        en = 1'b0;
        repeat (8) tick();
        req_valid = '0;
        tick();

        // Flush while idle.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (2) tick();

        // Reset two cycles after an issue discards the result.
        mode = M_CLEAR;
        set_req(1, 3, 3);
        en = 1'b1;
        n_grants = 0;
        for (int k = 0; k < 5 && n_grants < 1; k++) tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        en = 1'b0;
        repeat (8) tick();

`ifdef MUL_SHARE_CHECK_EN
        // Faulty product for 2*2 must raise the sticky checker flag.
        do_reset();
        fault_en = 1'b1;
        mode = M_CLEAR;
        set_req(2, 2, 2);
        en = 1'b1;
        repeat (3) tick();
        set_req(1, 1, 3);
        repeat (8) tick();
        en = 1'b0;
        repeat (4) tick();
        check("chk_sticky", chk_err, 1);
        fault_en = 1'b0;
        do_reset();
        tick();
        check("chk_cleared", chk_err, 0);
`endif

        // Randomized traffic with occasional flush, en drops and resets.
        mode = M_RAND;
        refill(-1);
        for (int k = 0; k < 400; k++) begin
            en    = ($urandom_range(0, 19) != 0);
            flush = ($urandom_range(0, 19) == 0);
            rst   = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0; en = 1'b0; flush = 1'b0;
        req_valid = '0;
        repeat (10) tick();
        check("end_idle_busy", busy, 0);
`ifndef MUL_SHARE_CHECK_EN
        check("chk_tied_off", chk_err, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mul_share_ctrl.md
Name: mul_share_ctrl

Overview:
- Scheduler that shares one fixed-latency 2-bit x 2-bit pipelined multiplier between NUM_REQ requesters.
- Round-robin arbitration; at most one operand pair issued per cycle; each result is routed back tagged with the requester ID.
- Sits between client blocks and the multiplier instance; the multiplier has no valid path of its own, so this block owns all validity tracking.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- ID_W, 2: requester ID width; must equal ceil(log2(NUM_REQ)).
- OP_W, 2: operand width.
- MUL_LAT, 4: multiplier edges from operand capture to product update.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  allow issuing.
- flush  in  1  stop issuing and drain the pipeline.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_a  in  NUM_REQ*OP_W  packed operand A; requester i uses slice [i*OP_W +: OP_W].
- req_b  in  NUM_REQ*OP_W  packed operand B, same packing.
- req_ready  out  NUM_REQ  one-hot grant.
- mul_a  out  OP_W  operand A to the multiplier, registered.
- mul_b  out  OP_W  operand B to the multiplier, registered.
- mul_p  in  2*OP_W  multiplier product.
- resp_valid  out  1  result valid.
- resp_id  out  ID_W  requester that owns the result.
- resp_p  out  2*OP_W  result; equals mul_p.
- busy  out  1  state != IDLE or any operation in flight.
- flush_done  out  1  one-cycle pulse when the drain completes.
- chk_err  out  1  sticky mismatch flag (see Optional Feature).

Behaviour:
- Reset: synchronous, active-high. Clears the following:
  - state to IDLE; round-robin pointer to 0.
  - tag pipeline to all-invalid.
  - mul_a, mul_b, req_ready, resp_valid, resp_id, flush_done, chk_err all to 0.
  - Operations in flight at reset are discarded: no resp_valid for them, even if mul_p later updates.
- FSM states:
  - IDLE: req_ready = 0. Goes to RUN when en=1 and flush=0.
  - RUN: grants and issues. Goes to DRAIN when flush=1 or en=0.
  - DRAIN: req_ready = 0. Goes to IDLE when the tag pipeline is empty; flush_done pulses in that transition cycle.
  - Flush arriving in IDLE with an empty pipeline: flush_done pulses in the next cycle; state stays IDLE.
- Arbitration (RUN only, and only when flush=0 and en=1):
  - req_ready is combinational from req_valid, one-hot.
  - Winner is the first asserted req_valid searching upward from the pointer, wrapping from NUM_REQ-1 to 0.
  - On a handshake (req_valid & req_ready) the pointer becomes winner+1, modulo NUM_REQ.
  - With no request pending, the pointer holds.
  - Requesters must hold req_a/req_b stable while req_valid is high and not granted.
- Issue:
  - At the handshake edge, mul_a/mul_b load the winner's operands and the tag {valid, id} enters the tag pipeline.
  - With no handshake, mul_a/mul_b load 0 and a bubble (valid=0) enters the pipeline.
  - Throughput is 1 issue per cycle; back-to-back issue is allowed.
- Response:
  - For a handshake in cycle C, resp_valid=1 and resp_id=winner in cycle C+MUL_LAT. resp_p = mul_p in that cycle.
  - Results return in issue order and have no backpressure; clients must accept them.
  - resp_valid and resp_id are registered. resp_p is passthrough.
- Simultaneous events:
  - flush plus req_valid in the same cycle: flush wins, no grant.
  - en falling mid-stream behaves like flush.
  - Responses keep being delivered during DRAIN.
- Arithmetic: the product is unsigned, 2*OP_W bits wide, with no overflow possible.

Optional Feature:
- Macro: MUL_SHARE_CHECK_EN.
- Defined: a parallel MUL_LAT-deep pipeline carries the reference product mul_a*mul_b. Whenever resp_valid=1 and mul_p differs from the reference, chk_err sets. Only rst clears it.
- Undefined: no check logic is built and chk_err is tied to 0.

Decomposition:
- Package mul_share_pkg holds:
  - state enum {IDLE, RUN, DRAIN};
  - OP_W default;
  - the product-width function;
  - the tag struct {valid, id}.
- One sub-module: rr_arbiter (NUM_REQ-wide round-robin grant plus pointer update), reusable elsewhere.
- The tag pipeline and FSM stay in the top module.

Test Plan:
- Single request: en=1, req 2 with a=3, b=2 handshake in cycle C → resp_valid, resp_id=2, resp_p=6 in cycle C+4; busy low afterwards.
- All four requesters held valid from pointer 0 → grants in order 0,1,2,3,0 with one grant per cycle; responses in the same order, 4 cycles after each grant.
- Back-to-back: 8 consecutive issues with operands from 0..3 → 8 consecutive resp_valid cycles, every product correct (e.g. 3*3=9), no bubbles.
- Flush after 3 issues → req_ready drops in the same cycle; the 3 responses still arrive; flush_done pulses once when the pipe empties; state returns to IDLE.
- rst asserted 2 cycles after an issue → no resp_valid for that issue; all outputs 0 in the cycle after reset.
- With MUL_SHARE_CHECK_EN: a faulty multiplier model returns 5 for 2*2 → chk_err goes to 1 and stays 1 until rst. Without the macro: chk_err stays 0.
